// File: rtl/snitch_vfpr_wb.sv
// rtl/snitch_vfpr_wb.sv - FPU result write-back buffer feeding the VFPR TCDM write port
//
// Buffers FPU results, turns each into a TCDM write, tracks in-flight writes
// until their in-order responses return, and publishes a per-register pending
// scoreboard that the read-issue logic uses to stall RAW reads.
//
// Optional feature macro: SNITCH_VFPR_WB_FWD_EN (forwarding lookup of buffered results).
//
// Ports:
//   clk_i        clock
//   rst_i        asynchronous active-high reset
//   res_idx_i    destination register index of the offered result
//   res_data_i   result data
//   res_valid_i  result valid
//   res_ready_o  result accepted when res_valid_i & res_ready_o
//   wr_req_o     packed TCDM request, MSB first:
//                {addr[AddrWidth], write, data[DataWidth], strb[DataWidth/8], amo[4], user, q_valid}
//   wr_rsp_i     packed TCDM response, MSB first: {q_ready, p_data[DataWidth], p_valid}
//   pending_o    bit r set while a write to register r is buffered or outstanding
//   idle_o       buffer empty and no writes outstanding
//   fwd_idx_i    (macro only) register index to look up in the buffer
//   fwd_hit_o    (macro only) youngest buffered entry matches fwd_idx_i
//   fwd_data_o   (macro only) data of that entry, zero on miss
module snitch_vfpr_wb #(
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned NumRegs        = 32,
  parameter logic [AddrWidth-1:0] BaseAddr = '0,
  parameter int unsigned BufDepth       = 2,
  parameter int unsigned MaxOutstanding = 4,
  localparam int unsigned IdxW  = $clog2(NumRegs),
  localparam int unsigned StrbW = DataWidth / 8,
  localparam int unsigned ReqW  = AddrWidth + 1 + DataWidth + StrbW + 4 + 1 + 1,
  localparam int unsigned RspW  = 1 + DataWidth + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [IdxW-1:0]      res_idx_i,
  input  logic [DataWidth-1:0] res_data_i,
  input  logic                 res_valid_i,
  output logic                 res_ready_o,
  output logic [ReqW-1:0]      wr_req_o,
  input  logic [RspW-1:0]      wr_rsp_i,
`ifdef SNITCH_VFPR_WB_FWD_EN
  input  logic [IdxW-1:0]      fwd_idx_i,
  output logic                 fwd_hit_o,
  output logic [DataWidth-1:0] fwd_data_o,
`endif
  output logic [NumRegs-1:0]   pending_o,
  output logic                 idle_o
);

  localparam int unsigned BufPtrW = (BufDepth > 1) ? $clog2(BufDepth) : 1;
  localparam int unsigned BufCntW = $clog2(BufDepth + 1);
  localparam int unsigned AckPtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned OutCntW = $clog2(MaxOutstanding + 1);
  localparam logic [BufCntW-1:0] BufFull = BufCntW'(BufDepth);
  localparam logic [OutCntW-1:0] OutMax  = OutCntW'(MaxOutstanding);
  localparam logic [3:0]         AmoNone = 4'h0;

  // Result buffer (circular FIFO) and in-order ack queue of issued indices.
  logic [IdxW-1:0]      buf_idx_q  [BufDepth];
  logic [DataWidth-1:0] buf_data_q [BufDepth];
  logic [BufPtrW-1:0]   buf_wr_ptr_q, buf_wr_ptr_d, buf_rd_ptr_q, buf_rd_ptr_d;
  logic [BufCntW-1:0]   buf_cnt_q, buf_cnt_d;
  logic [IdxW-1:0]      ack_idx_q  [MaxOutstanding];
  logic [AckPtrW-1:0]   ack_wr_ptr_q, ack_wr_ptr_d, ack_rd_ptr_q, ack_rd_ptr_d;
  logic [OutCntW-1:0]   out_cnt_q, out_cnt_d;
  logic [NumRegs-1:0]   pending_q, pending_d;

  logic                 rsp_q_ready, rsp_p_valid;
  logic [DataWidth-1:0] rsp_p_data_unused;
  logic                 buf_full, buf_empty, q_valid;
  logic                 accept, issue, retire;
  logic [IdxW-1:0]      head_idx;
  logic [DataWidth-1:0] head_data;
  logic [AddrWidth-1:0] req_addr;

  assign {rsp_q_ready, rsp_p_data_unused, rsp_p_valid} = wr_rsp_i;

  function automatic logic [BufPtrW-1:0] buf_ptr_inc(input logic [BufPtrW-1:0] p);
    return (p == BufPtrW'(BufDepth - 1)) ? '0 : p + BufPtrW'(1);
  endfunction

  function automatic logic [AckPtrW-1:0] ack_ptr_inc(input logic [AckPtrW-1:0] p);
    return (p == AckPtrW'(MaxOutstanding - 1)) ? '0 : p + AckPtrW'(1);
  endfunction

  assign buf_full  = (buf_cnt_q == BufFull);
  assign buf_empty = (buf_cnt_q == '0);

  // The WAW check uses registered pending state only, so a response arriving in
  // the same cycle does not unblock the new write; it is taken one cycle later.
  // This also keeps q_ready out of the res_ready_o cone.
  assign res_ready_o = ~buf_full & ~pending_q[res_idx_i];
  assign accept      = res_valid_i & res_ready_o;
  assign q_valid     = ~buf_empty & (out_cnt_q != OutMax);
  assign issue       = q_valid & rsp_q_ready;
  // A response with nothing outstanding (e.g. in flight across reset) is dropped.
  assign retire      = rsp_p_valid & (out_cnt_q != '0);

  always_comb begin
    buf_wr_ptr_d = buf_wr_ptr_q;
    buf_rd_ptr_d = buf_rd_ptr_q;
    buf_cnt_d    = buf_cnt_q;
    ack_wr_ptr_d = ack_wr_ptr_q;
    ack_rd_ptr_d = ack_rd_ptr_q;
    out_cnt_d    = out_cnt_q;
    pending_d    = pending_q;

    if (accept) buf_wr_ptr_d = buf_ptr_inc(buf_wr_ptr_q);
    if (issue)  buf_rd_ptr_d = buf_ptr_inc(buf_rd_ptr_q);
    case ({accept, issue})
      2'b10:   buf_cnt_d = buf_cnt_q + BufCntW'(1);
      2'b01:   buf_cnt_d = buf_cnt_q - BufCntW'(1);
      default: buf_cnt_d = buf_cnt_q;
    endcase

    if (issue)  ack_wr_ptr_d = ack_ptr_inc(ack_wr_ptr_q);
    if (retire) ack_rd_ptr_d = ack_ptr_inc(ack_rd_ptr_q);
    case ({issue, retire})
      2'b10:   out_cnt_d = out_cnt_q + OutCntW'(1);
      2'b01:   out_cnt_d = out_cnt_q - OutCntW'(1);
      default: out_cnt_d = out_cnt_q;
    endcase

    // Accepted index is never pending, so it cannot collide with the retired one.
    if (retire) pending_d[ack_idx_q[ack_rd_ptr_q]] = 1'b0;
    if (accept) pending_d[res_idx_i] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      buf_wr_ptr_q <= '0;
      buf_rd_ptr_q <= '0;
      buf_cnt_q    <= '0;
      ack_wr_ptr_q <= '0;
      ack_rd_ptr_q <= '0;
      out_cnt_q    <= '0;
      pending_q    <= '0;
    end else begin
      buf_wr_ptr_q <= buf_wr_ptr_d;
      buf_rd_ptr_q <= buf_rd_ptr_d;
      buf_cnt_q    <= buf_cnt_d;
      ack_wr_ptr_q <= ack_wr_ptr_d;
      ack_rd_ptr_q <= ack_rd_ptr_d;
      out_cnt_q    <= out_cnt_d;
      pending_q    <= pending_d;
    end
  end

  // Storage arrays need no reset: occupancy is tracked by the pointers/counters.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      buf_idx_q[buf_wr_ptr_q]  <= res_idx_i;
      buf_data_q[buf_wr_ptr_q] <= res_data_i;
    end
    if (issue) ack_idx_q[ack_wr_ptr_q] <= head_idx;
  end

  assign head_idx  = buf_idx_q[buf_rd_ptr_q];
  assign head_data = buf_data_q[buf_rd_ptr_q];
  assign req_addr  = BaseAddr + AddrWidth'(head_idx) * AddrWidth'(StrbW);

  // Request fields come straight from the FIFO head, which only moves on a
  // handshake, so the payload holds steady under backpressure.
  assign wr_req_o  = {req_addr, 1'b1, head_data, {StrbW{1'b1}}, AmoNone, 1'b0, q_valid};
  assign pending_o = pending_q;
  assign idle_o    = buf_empty & (out_cnt_q == '0);

`ifdef SNITCH_VFPR_WB_FWD_EN
  logic [BufPtrW-1:0] fwd_slot;

  // Walk the buffer oldest to youngest so the youngest match wins.
  always_comb begin
    fwd_hit_o  = 1'b0;
    fwd_data_o = '0;
    fwd_slot   = '0;
    for (int unsigned i = 0; i < BufDepth; i++) begin
      fwd_slot = BufPtrW'((32'(buf_rd_ptr_q) + i) % BufDepth);
      if ((BufCntW'(i) < buf_cnt_q) && (buf_idx_q[fwd_slot] == fwd_idx_i)) begin
        fwd_hit_o  = 1'b1;
        fwd_data_o = buf_data_q[fwd_slot];
      end
    end
  end
`endif

endmodule

// File: doc/snitch_vfpr_wb.md
Name: snitch_vfpr_wb

Overview:
- Write-back stage directly upstream of the VFPR write port.
- Accepts FPU results (register index, data) over a valid/ready handshake and buffers them.
- Converts each result into a TCDM write request for the VFPR interconnect, tracks outstanding writes until their responses return, and publishes a per-register pending scoreboard.
- The VFPR read-issue logic uses the scoreboard to stall RAW reads.

Parameters:
- DataWidth, 64, width of one FP register and of the TCDM data bus.
- AddrWidth, 32, TCDM address width.
- NumRegs, 32, number of architectural FP registers; index width IdxW = $clog2(NumRegs).
- BaseAddr, 0, byte address of register 0 in the VFPR memory.
- BufDepth, 2, depth of the result buffer FIFO (>=1).
- MaxOutstanding, 4, maximum writes issued but not yet acknowledged (>=1).
- tcdm_req_t, logic, TCDM request struct (q, q_valid).
- tcdm_rsp_t, logic, TCDM response struct (q_ready, p, p_valid).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset. One clock; reset is asynchronous and active-high.
- res_idx_i  in  IdxW  destination register index.
- res_data_i  in  DataWidth  result data.
- res_valid_i  in  1  result valid.
- res_ready_o  out  1  result accepted when valid & ready.
- wr_req_o  out  tcdm_req_t  write request to VFPR write port.
- wr_rsp_i  in  tcdm_rsp_t  response from VFPR write port.
- pending_o  out  NumRegs  bit r set while a write to register r is buffered or outstanding.
- idle_o  out  1  high when buffer empty and no writes outstanding.

Behaviour:
- Reset: FIFO empty; outstanding count 0; pending_o = 0; wr_req_o.q_valid = 0; idle_o = 1; res_ready_o = 1 (nothing pending, buffer not full).
- res_ready_o = ~fifo_full & ~pending_q[res_idx_i]. WAW stall: a second write to a register already pending is refused, even if its response arrives in the same cycle (conservative; the bit clears first, the write is accepted one cycle later).
- On accept at cycle N:
  - Entry {idx, data} is pushed to the FIFO (not fall-through).
  - pending_q[idx] is set at the N edge, so it is visible from N+1.
  - Earliest q_valid is at N+1.
- Request fields:
  - addr = BaseAddr + idx * (DataWidth/8), truncated to AddrWidth.
  - write = 1; data = entry data; strb = all ones; amo = AMONone; user = 0.
- Issue: q_valid = ~fifo_empty & (outstanding < MaxOutstanding).
  - q must stay stable while q_valid & ~q_ready.
  - On q_valid & q_ready: pop the FIFO, push idx into the in-order ack queue (depth MaxOutstanding), outstanding += 1.
- Response: each p_valid acknowledges the oldest outstanding write (interconnect returns write responses in order).
  - On p_valid: pop the ack queue head h, clear pending_q[h], outstanding -= 1.
  - pending bit is low from the cycle after p_valid.
- Simultaneous issue and response in one cycle: the count is unchanged; the ack-queue push and pop both take effect.
- Simultaneous accept (set bit a) and response (clear bit b), a != b: both applied.
- p_valid with outstanding = 0 (e.g. a response in flight across reset) is ignored: no state change, no underflow.
- Full / empty:
  - Full FIFO deasserts res_ready_o.
  - outstanding = MaxOutstanding holds q_valid low even with data buffered.
  - Empty FIFO: q_valid = 0.
- idle_o = fifo_empty & (outstanding == 0), registered-state based (no combinational path from inputs).
- Reset asserted mid-operation: all buffered and outstanding writes are dropped; all state returns to reset values immediately (asynchronous).
- No combinational path from wr_rsp_i.q_ready to res_ready_o.

Optional Feature:
- Macro SNITCH_VFPR_WB_FWD_EN.
- Defined: adds ports fwd_idx_i (in, IdxW), fwd_hit_o (out, 1), fwd_data_o (out, DataWidth).
  - Combinational lookup of the youngest FIFO entry with idx == fwd_idx_i.
  - On a match: fwd_hit_o = 1 and fwd_data_o = entry data. Otherwise fwd_hit_o = 0 and fwd_data_o = 0.
  - Writes already issued but unacknowledged do not hit.
  - This lets the read stage bypass buffered results.
- Undefined: these ports and the lookup logic do not exist; all other behaviour is identical.

Test Plan:
- Setup: DataWidth=64, BaseAddr=0x1000, BufDepth=2, MaxOutstanding=4.
- Single write: res_idx=3, data=0xDEADBEEF, q_ready=1 -> q_valid at N+1 with addr=0x1018, write=1, strb=0xFF; pending_o[3]=1 from N+1; p_valid at N+3 -> pending_o[3]=0 at N+4, idle_o=1.
- WAW stall: accept idx 5, then present idx 5 again -> res_ready_o=0 until the cycle after the first p_valid; second write then accepted with correct data.
- Backpressure: q_ready held 0, offer idx 1,2,3 -> first two accepted, res_ready_o=0 on the third; q.addr/q.data stable at 0x1008 throughout.
- Outstanding limit: q_ready=1, p_valid withheld, 6 distinct writes offered -> exactly 4 issued, q_valid=0 with 2 buffered; one p_valid -> a 5th issues the next cycle; pending clears in issue order.
- Reset mid-operation: 2 buffered + 2 outstanding, pulse rst_i -> pending_o=0, q_valid=0, idle_o=1 immediately; a stray p_valid afterwards causes no change.
- Forwarding (macro defined): q_ready=0, buffer idx 7 = 0xA then idx 7 blocked; fwd_idx_i=7 -> hit=1, data=0xA; fwd_idx_i=8 -> hit=0.
